// File: rtl/rlwe_pipe_vlsu_burst.sv
// Multi-beat vector load/store unit between the RLWE EXU and the DMEM port.
// Optional feature macro RLWE_VLSU_STRIDE_EN adds a programmable per-beat byte stride.
module rlwe_pipe_vlsu_burst #(
  parameter int LANE      = 4,
  parameter int XLEN      = 32,
  parameter int AWIDTH    = 32,
  parameter int MAX_BEATS = 128,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1),
  localparam int DW       = LANE * XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu2vlsu_req,
  input  logic              exu2vlsu_store,
  input  logic [AWIDTH-1:0] exu2vlsu_addr,
  input  logic [CNT_W-1:0]  exu2vlsu_beats,
  input  logic              exu2vlsu_kill,
  input  logic [DW-1:0]     exu2vlsu_s_data,
`ifdef RLWE_VLSU_STRIDE_EN
  input  logic [AWIDTH-1:0] exu2vlsu_stride,
`endif
  output logic              vlsu2exu_s_pop,
  output logic              vlsu2exu_l_vld,
  output logic [DW-1:0]     vlsu2exu_l_data,
  output logic [CNT_W-1:0]  vlsu2exu_l_idx,
  output logic              vlsu2exu_rdy,
  output logic              vlsu2exu_exc,
  output logic [3:0]        vlsu2exu_exc_code,
  output logic              vlsu_busy,
  output logic              vlsu2dmem_req,
  output logic              vlsu2dmem_cmd,
  output logic [AWIDTH-1:0] vlsu2dmem_addr,
  output logic [DW-1:0]     vlsu2dmem_wdata,
  input  logic              dmem2vlsu_req_ack,
  input  logic [DW-1:0]     dmem2vlsu_rdata,
  input  logic [1:0]        dmem2vlsu_resp
);

  localparam int         ALIGN_W    = $clog2(LANE) + 2;
  localparam logic [1:0] RESP_OK    = 2'd1;
  localparam logic [1:0] RESP_ER    = 2'd2;
  localparam logic [3:0] EXC_LD_MIS = 4'd4;
  localparam logic [3:0] EXC_LD_FLT = 4'd5;
  localparam logic [3:0] EXC_ST_MIS = 4'd6;
  localparam logic [3:0] EXC_ST_FLT = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [AWIDTH-1:0] r_addr;
  logic [CNT_W-1:0]  r_beats;
  logic [CNT_W-1:0]  r_count;
  logic              r_store;
  logic              r_killed;
  logic              r_excPend;
  logic [3:0]        r_excCodePend;
  logic              r_rdyPend;

  logic [AWIDTH-1:0] w_stride;
  logic              w_misalign;
  logic [CNT_W-1:0]  w_countInc;
  logic              w_lastBeat;
  logic              w_killed;
  logic              w_dmemReq;
  logic              w_lVld;
  logic              w_sPop;
  logic              w_rdyBurst;
  logic              w_excResp;

`ifdef RLWE_VLSU_STRIDE_EN
  logic [AWIDTH-1:0] r_stride;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stride <= '0;
    end else if (r_state == S_IDLE && exu2vlsu_req) begin
      r_stride <= exu2vlsu_stride;
    end
  end

  assign w_stride   = r_stride;
  assign w_misalign = (exu2vlsu_addr[ALIGN_W-1:0] != '0) ||
                      (exu2vlsu_stride[ALIGN_W-1:0] != '0);
`else
  localparam logic [AWIDTH-1:0] BEAT_BYTES = AWIDTH'(LANE * 4);

  assign w_stride   = BEAT_BYTES;
  assign w_misalign = exu2vlsu_addr[ALIGN_W-1:0] != '0;
`endif

  assign w_countInc = r_count + CNT_W'(1);
  assign w_lastBeat = (w_countInc == r_beats);
  // A kill seen earlier in RESP must still hold while the response is awaited.
  assign w_killed   = exu2vlsu_kill || r_killed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_beats       <= '0;
      r_count       <= '0;
      r_store       <= 1'b0;
      r_killed      <= 1'b0;
      r_excPend     <= 1'b0;
      r_excCodePend <= 4'd0;
      r_rdyPend     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_excPend <= 1'b0;
      r_rdyPend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exu2vlsu_req) begin
            if (w_misalign) begin
              r_excPend     <= 1'b1;
              r_excCodePend <= exu2vlsu_store ? EXC_ST_MIS : EXC_LD_MIS;
            end else if (exu2vlsu_beats == '0) begin
              r_rdyPend <= 1'b1;
            end else begin
              r_addr   <= exu2vlsu_addr;
              r_beats  <= exu2vlsu_beats;
              r_store  <= exu2vlsu_store;
              r_count  <= '0;
              r_killed <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (dmem2vlsu_req_ack && exu2vlsu_kill) r_killed <= 1'b1;
        end
        S_RESP: begin
          if (exu2vlsu_kill) r_killed <= 1'b1;
          if (dmem2vlsu_resp == RESP_OK) begin
            r_count <= w_countInc;
            r_addr  <= r_addr + w_stride;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_dmemReq   = 1'b0;
    w_lVld      = 1'b0;
    w_sPop      = 1'b0;
    w_rdyBurst  = 1'b0;
    w_excResp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (exu2vlsu_req && !w_misalign && exu2vlsu_beats != '0) w_nextState = S_REQ;
      end
      S_REQ: begin
        w_dmemReq = 1'b1;
        if (dmem2vlsu_req_ack)  w_nextState = S_RESP;
        else if (exu2vlsu_kill) w_nextState = S_IDLE;
      end
      S_RESP: begin
        if (dmem2vlsu_resp == RESP_OK) begin
          w_lVld      = !r_store && !w_killed;
          w_sPop      = r_store && !w_killed;
          w_rdyBurst  = w_lastBeat && !w_killed;
          w_nextState = (w_lastBeat || w_killed) ? S_IDLE : S_REQ;
        end else if (dmem2vlsu_resp == RESP_ER) begin
          w_excResp   = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign vlsu2exu_s_pop    = w_sPop;
  assign vlsu2exu_l_vld    = w_lVld;
  assign vlsu2exu_l_data   = w_lVld ? dmem2vlsu_rdata : '0;
  assign vlsu2exu_l_idx    = w_lVld ? r_count : '0;
  assign vlsu2exu_rdy      = r_rdyPend || w_rdyBurst;
  assign vlsu2exu_exc      = r_excPend || w_excResp;
  assign vlsu2exu_exc_code = r_excPend ? r_excCodePend :
                             w_excResp ? (r_store ? EXC_ST_FLT : EXC_LD_FLT) : 4'd0;
  assign vlsu_busy         = (r_state != S_IDLE);
  assign vlsu2dmem_req     = w_dmemReq;
  assign vlsu2dmem_cmd     = w_dmemReq && r_store;
  assign vlsu2dmem_addr    = r_addr;
  assign vlsu2dmem_wdata   = exu2vlsu_s_data;

endmodule

// File: tb/tb_rlwe_pipe_vlsu_burst.sv
// Self-checking bench for rlwe_pipe_vlsu_burst: directed scenarios plus randomized bursts
// checked cycle by cycle against a beat-timeline model of the EXU/DMEM exchange.
module tb_rlwe_pipe_vlsu_burst;

  localparam int LANE      = 4;
  localparam int XLEN      = 32;
  localparam int AWIDTH    = 32;
  localparam int MAX_BEATS = 128;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int DW        = LANE * XLEN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              exu2vlsu_req;
  logic              exu2vlsu_store;
  logic [AWIDTH-1:0] exu2vlsu_addr;
  logic [CNT_W-1:0]  exu2vlsu_beats;
  logic              exu2vlsu_kill;
  logic [DW-1:0]     exu2vlsu_s_data;
  logic [AWIDTH-1:0] exu2vlsu_stride;
  logic              vlsu2exu_s_pop;
  logic              vlsu2exu_l_vld;
  logic [DW-1:0]     vlsu2exu_l_data;
  logic [CNT_W-1:0]  vlsu2exu_l_idx;
  logic              vlsu2exu_rdy;
  logic              vlsu2exu_exc;
  logic [3:0]        vlsu2exu_exc_code;
  logic              vlsu_busy;
  logic              vlsu2dmem_req;
  logic              vlsu2dmem_cmd;
  logic [AWIDTH-1:0] vlsu2dmem_addr;
  logic [DW-1:0]     vlsu2dmem_wdata;
  logic              dmem2vlsu_req_ack;
  logic [DW-1:0]     dmem2vlsu_rdata;
  logic [1:0]        dmem2vlsu_resp;

  always #5 clk = ~clk;

  rlwe_pipe_vlsu_burst #(
    .LANE(LANE), .XLEN(XLEN), .AWIDTH(AWIDTH), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exu2vlsu_req      (exu2vlsu_req),
    .exu2vlsu_store    (exu2vlsu_store),
    .exu2vlsu_addr     (exu2vlsu_addr),
    .exu2vlsu_beats    (exu2vlsu_beats),
    .exu2vlsu_kill     (exu2vlsu_kill),
    .exu2vlsu_s_data   (exu2vlsu_s_data),
`ifdef RLWE_VLSU_STRIDE_EN
    .exu2vlsu_stride   (exu2vlsu_stride),
`endif
    .vlsu2exu_s_pop    (vlsu2exu_s_pop),
    .vlsu2exu_l_vld    (vlsu2exu_l_vld),
    .vlsu2exu_l_data   (vlsu2exu_l_data),
    .vlsu2exu_l_idx    (vlsu2exu_l_idx),
    .vlsu2exu_rdy      (vlsu2exu_rdy),
    .vlsu2exu_exc      (vlsu2exu_exc),
    .vlsu2exu_exc_code (vlsu2exu_exc_code),
    .vlsu_busy         (vlsu_busy),
    .vlsu2dmem_req     (vlsu2dmem_req),
    .vlsu2dmem_cmd     (vlsu2dmem_cmd),
    .vlsu2dmem_addr    (vlsu2dmem_addr),
    .vlsu2dmem_wdata   (vlsu2dmem_wdata),
    .dmem2vlsu_req_ack (dmem2vlsu_req_ack),
    .dmem2vlsu_rdata   (dmem2vlsu_rdata),
    .dmem2vlsu_resp    (dmem2vlsu_resp)
  );

  int checks = 0;
  int passes = 0;

  // Transaction descriptor consumed by applyStimulus
  logic          txStore;
  logic [31:0]   txAddr;
  logic [31:0]   txStride;
  int            txBeats;
  int            txErrBeat;
  int            txKillMode;   // 0 none, 1 kill in RESP, 2 kill in REQ before ack
  int            txKillBeat;
  int            txAckD;
  int            txRespD;
  logic [DW-1:0] sData [MAX_BEATS+1];
  int            popCnt;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [DW-1:0] randWide();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic setTxn(input logic st, input logic [31:0] addr, input logic [31:0] stride,
                        input int beats, input int errBeat, input int killMode,
                        input int killBeat, input int ackD, input int respD);
    txStore = st; txAddr = addr; txStride = stride; txBeats = beats;
    txErrBeat = errBeat; txKillMode = killMode; txKillBeat = killBeat;
    txAckD = ackD; txRespD = respD;
  endtask

  task automatic idleInputs();
    exu2vlsu_req = 1'b0; exu2vlsu_store = 1'b0; exu2vlsu_addr = '0; exu2vlsu_beats = '0;
    exu2vlsu_kill = 1'b0; exu2vlsu_s_data = '0; exu2vlsu_stride = 32'h10;
    dmem2vlsu_req_ack = 1'b0; dmem2vlsu_rdata = '0; dmem2vlsu_resp = 2'd0;
  endtask

  // Each beat takes (ackD+1) request cycles then (respD+1) response cycles; cycle 0 is the issue.
  task automatic applyStimulus();
    bit misal;
    bit active;
    int per;
    int endCycle;
    per = 2 + txAckD + txRespD;
    misal = (txAddr[3:0] != 4'd0) || (txStride[3:0] != 4'd0);
    active = !misal && (txBeats != 0);
    endCycle = 1;
    if (active) begin
      for (int k = 0; k < txBeats; k++) begin
        if (txKillMode == 2 && k == txKillBeat) begin
          endCycle = k * per + 1;
          break;
        end
        endCycle = (k + 1) * per;
        if (k == txErrBeat) break;
        if (txKillMode == 1 && k == txKillBeat) break;
      end
    end
    for (int i = 0; i <= MAX_BEATS; i++) sData[i] = randWide();
    popCnt = 0;

    @(negedge clk);
    idleInputs();
    exu2vlsu_req    = 1'b1;
    exu2vlsu_store  = txStore;
    exu2vlsu_addr   = txAddr;
    exu2vlsu_beats  = CNT_W'(txBeats);
    exu2vlsu_stride = txStride;
    exu2vlsu_s_data = sData[0];
    #1;
    checkOutput("issue_busy", vlsu_busy, 1'b0);

    for (int c = 1; c <= endCycle; c++) begin
      int k;
      int o;
      bit isReq;
      bit isResp;
      bit ok;
      bit quiet;
      bit deliver;
      logic [DW-1:0] rd;
      logic [31:0] expAddr;
      @(negedge clk);
      k = (c - 1) / per;
      o = (c - 1) % per;
      isReq   = active && (o <= txAckD);
      isResp  = active && (o == per - 1);
      ok      = (k != txErrBeat);
      quiet   = (txKillMode == 1 && k == txKillBeat);
      deliver = isResp && ok && !quiet;
      rd      = randWide();
      exu2vlsu_req = active;
      if (active) begin
        exu2vlsu_addr   = $urandom();
        exu2vlsu_beats  = CNT_W'($urandom_range(0, MAX_BEATS));
        exu2vlsu_store  = 1'($urandom_range(0, 1));
        exu2vlsu_stride = $urandom();
      end
      exu2vlsu_kill = active && ((txKillMode == 2 && k == txKillBeat && o == 0) ||
                                 (txKillMode == 1 && k == txKillBeat && o == txAckD + 1));
      dmem2vlsu_req_ack = isReq && (o == txAckD) && !(txKillMode == 2 && k == txKillBeat);
      dmem2vlsu_resp    = isResp ? (ok ? 2'd1 : 2'd2) : 2'd0;
      dmem2vlsu_rdata   = rd;
      exu2vlsu_s_data   = sData[popCnt];
      #1;
      expAddr = txAddr + 32'(k) * txStride;
      checkOutput("dmem_req", vlsu2dmem_req, isReq);
      if (isReq) begin
        checkOutput("dmem_addr", vlsu2dmem_addr, expAddr);
        checkOutput("dmem_cmd", vlsu2dmem_cmd, txStore);
        if (txStore) checkOutput("dmem_wdata", vlsu2dmem_wdata, sData[k]);
      end
      checkOutput("busy", vlsu_busy, active);
      checkOutput("l_vld", vlsu2exu_l_vld, deliver && !txStore);
      if (deliver && !txStore) begin
        checkOutput("l_data", vlsu2exu_l_data, rd);
        checkOutput("l_idx", vlsu2exu_l_idx, CNT_W'(k));
      end
      checkOutput("s_pop", vlsu2exu_s_pop, deliver && txStore);
      checkOutput("rdy", vlsu2exu_rdy, (deliver && k == txBeats - 1) || (!active && !misal));
      checkOutput("exc", vlsu2exu_exc, (isResp && !ok) || misal);
      if (misal)
        checkOutput("exc_code", vlsu2exu_exc_code, txStore ? 4'd6 : 4'd4);
      else if (isResp && !ok)
        checkOutput("exc_code", vlsu2exu_exc_code, txStore ? 4'd7 : 4'd5);
      if (vlsu2exu_s_pop && popCnt < MAX_BEATS) popCnt++;
    end

    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("end_busy", vlsu_busy, 1'b0);
    checkOutput("end_dmem_req", vlsu2dmem_req, 1'b0);
    checkOutput("end_rdy", vlsu2exu_rdy, 1'b0);
    checkOutput("end_exc", vlsu2exu_exc, 1'b0);
  endtask

  initial begin
    logic [31:0] rStride;
    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", vlsu_busy, 1'b0);
    checkOutput("rst_dmem_req", vlsu2dmem_req, 1'b0);
    checkOutput("rst_dmem_addr", vlsu2dmem_addr, 32'h0);
    checkOutput("rst_rdy", vlsu2exu_rdy, 1'b0);
    checkOutput("rst_exc", vlsu2exu_exc, 1'b0);
    checkOutput("rst_exc_code", vlsu2exu_exc_code, 4'd0);
    checkOutput("rst_l_vld", vlsu2exu_l_vld, 1'b0);
    checkOutput("rst_l_data", vlsu2exu_l_data, '0);
    checkOutput("rst_l_idx", vlsu2exu_l_idx, '0);
    checkOutput("rst_s_pop", vlsu2exu_s_pop, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    setTxn(1'b0, 32'h0048_0000, 32'h10, 4, -1, 0, 0, 0, 0);   applyStimulus();
    setTxn(1'b1, 32'h0048_0004, 32'h10, 4, -1, 0, 0, 0, 0);   applyStimulus();
    setTxn(1'b0, 32'h0000_4000, 32'h10, 3,  1, 0, 0, 0, 1);   applyStimulus();
    setTxn(1'b0, 32'hFFFF_FF00, 32'h10, 128, -1, 0, 0, 0, 0); applyStimulus();
    setTxn(1'b0, 32'h0000_8000, 32'h10, 4, -1, 1, 2, 1, 2);   applyStimulus();
    setTxn(1'b1, 32'h0000_9000, 32'h10, 3, -1, 0, 0, 2, 0);   applyStimulus();
    setTxn(1'b1, 32'h0000_A000, 32'h10, 0, -1, 0, 0, 0, 0);   applyStimulus();
    setTxn(1'b1, 32'h0000_B000, 32'h10, 4, -1, 2, 1, 2, 1);   applyStimulus();
    setTxn(1'b1, 32'h0000_C000, 32'h10, 4,  2, 1, 2, 0, 1);   applyStimulus();
`ifdef RLWE_VLSU_STRIDE_EN
    setTxn(1'b0, 32'h0000_2000, 32'h40, 2, -1, 0, 0, 0, 0);   applyStimulus();
    setTxn(1'b1, 32'h0000_2000, 32'h44, 2, -1, 0, 0, 0, 0);   applyStimulus();
    setTxn(1'b1, 32'h0000_3000, 32'h00, 3, -1, 0, 0, 1, 0);   applyStimulus();
`endif

    // Reset asserted while a burst is waiting for DMEM must drop straight back to idle
    @(negedge clk);
    exu2vlsu_req = 1'b1; exu2vlsu_addr = 32'h0000_1000; exu2vlsu_beats = CNT_W'(4);
    @(negedge clk);
    exu2vlsu_req = 1'b0;
    #1;
    checkOutput("midrst_busy_before", vlsu_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", vlsu_busy, 1'b0);
    checkOutput("midrst_dmem_req", vlsu2dmem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    setTxn(1'b0, 32'h0000_1000, 32'h10, 2, -1, 0, 0, 0, 0);   applyStimulus();

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      int b;
      b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      a = $urandom() & 32'hFFFF_FFF0;
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFC0;
      rStride = 32'h10;
`ifdef RLWE_VLSU_STRIDE_EN
      case ($urandom_range(0, 4))
        0: rStride = 32'h0;
        1: rStride = 32'h40;
        2: rStride = $urandom() & 32'h0000_FFF0;
        3: rStride = 32'h10 | 32'($urandom_range(1, 15));
        default: rStride = 32'h10;
      endcase
`endif
      setTxn(1'($urandom_range(0, 1)), a, rStride, b,
             ($urandom_range(0, 2) == 0 && b > 0) ? $urandom_range(0, b - 1) : -1,
             $urandom_range(0, 4) > 2 ? $urandom_range(1, 2) : 0,
             b > 0 ? $urandom_range(0, b - 1) : 0,
             $urandom_range(0, 2), $urandom_range(0, 2));
      if (txKillMode == 2 && txAckD == 0) txAckD = 1;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
